// File: rtl/bp_gshare.sv
// Gshare branch direction predictor: PC xor GHR indexes a 2-bit counter PHT; response one cycle after accept.
// Build with BP_BYPASS_EN defined to forward a same-cycle update into the lookup result.
module bp_gshare #(
    parameter int XLEN      = 64,
    parameter int PHT_IDX_W = 10,
    parameter int GHR_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid_i,
    input  logic [XLEN-1:0]      pred_pc_i,
    output logic                 pred_ready_o,
    output logic                 pred_rsp_valid_o,
    output logic                 pred_taken_o,
    output logic [PHT_IDX_W-1:0] pred_idx_o,
    output logic [GHR_W-1:0]     pred_ghr_o,
    input  logic                 upd_valid_i,
    input  logic [PHT_IDX_W-1:0] upd_idx_i,
    input  logic                 upd_taken_i,
    input  logic                 upd_mispredict_i,
    input  logic [GHR_W-1:0]     upd_ghr_i
);

    typedef enum logic {INIT, READY} state_t;

    state_t               state, state_nxt;
    logic [PHT_IDX_W-1:0] sweep;
    logic [GHR_W-1:0]     ghr;
    logic [1:0]           pht [2**PHT_IDX_W];

    logic [PHT_IDX_W-1:0] idx;
    logic [1:0]           upd_old, upd_new, rd_ctr;
    logic                 accept, pht_we, upd_en;
    logic [PHT_IDX_W-1:0] wr_idx;
    logic [1:0]           wr_dat;
    logic                 unused_pc;

    assign unused_pc = ^{pred_pc_i[XLEN-1:PHT_IDX_W+2], pred_pc_i[1:0]};

    assign idx     = pred_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign upd_old = pht[upd_idx_i];
    assign upd_new = upd_taken_i ? ((upd_old == 2'b11) ? 2'b11 : upd_old + 2'b01)
                                 : ((upd_old == 2'b00) ? 2'b00 : upd_old - 2'b01);
    assign upd_en  = (state == READY) && upd_valid_i;
    assign accept  = pred_valid_i && pred_ready_o;

`ifdef BP_BYPASS_EN
    assign rd_ctr = (upd_valid_i && (upd_idx_i == idx)) ? upd_new : pht[idx];
`else
    assign rd_ctr = pht[idx];
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        pred_ready_o = 1'b0;
        pht_we       = 1'b0;
        wr_idx       = upd_idx_i;
        wr_dat       = upd_new;
        case (state)
            INIT: begin
                pht_we = 1'b1;
                wr_idx = sweep;
                wr_dat = 2'b01;
                if (&sweep) state_nxt = READY;
            end
            READY: begin
                // A mispredict repair owns the GHR this cycle, so lookups stall.
                pred_ready_o = !rst && !(upd_valid_i && upd_mispredict_i);
                pht_we       = upd_valid_i;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pht_we) pht[wr_idx] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep            <= '0;
            ghr              <= '0;
            pred_rsp_valid_o <= 1'b0;
            pred_taken_o     <= 1'b0;
            pred_idx_o       <= '0;
            pred_ghr_o       <= '0;
        end else begin
            if (state == INIT) sweep <= sweep + 1'b1;
            pred_rsp_valid_o <= accept;
            if (accept) begin
                pred_taken_o <= rd_ctr[1];
                pred_idx_o   <= idx;
                pred_ghr_o   <= ghr;
                ghr          <= GHR_W'({ghr, rd_ctr[1]});
            end
            if (upd_en && upd_mispredict_i) ghr <= GHR_W'({upd_ghr_i, upd_taken_i});
        end
    end

endmodule

// File: tb/tb_bp_gshare.sv
// Randomized bench for bp_gshare against a behavioural gshare model, plus directed literal checks.
// Define BP_BYPASS_EN for both bench and RTL when building the forwarding variant.
module tb_bp_gshare;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_valid = 1'b0;
    logic [63:0] pred_pc = '0;
    logic        pred_ready, pred_rsp_valid, pred_taken;
    logic [9:0]  pred_idx, pred_ghr;
    logic        upd_valid = 1'b0;
    logic [9:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic [9:0]  upd_ghr = '0;

    int checks = 0;
    int errors = 0;

    bp_gshare #(.XLEN(64), .PHT_IDX_W(10), .GHR_W(10)) dut (
        .clk(clk), .rst(rst),
        .pred_valid_i(pred_valid), .pred_pc_i(pred_pc), .pred_ready_o(pred_ready),
        .pred_rsp_valid_o(pred_rsp_valid), .pred_taken_o(pred_taken),
        .pred_idx_o(pred_idx), .pred_ghr_o(pred_ghr),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
        .upd_mispredict_i(upd_mispredict), .upd_ghr_i(upd_ghr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: counters as ints 0..3, history as an int, init as a countdown.
    int m_pht [1024];
    int m_ghr = 0;
    int m_init_left = 0;
    bit m_known = 0;
    logic       e_vld = 0, e_taken = 0;
    logic [9:0] e_idx = 0, e_ghr = 0;

    function automatic int sat(input int c, input logic up);
        if (up) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    always @(negedge clk) begin
        int i, c;
        bit acc;
        if (m_known) begin
            chk("ready", pred_ready,
                !rst && m_init_left == 0 && !(upd_valid && upd_mispredict));
            chk("rsp_valid", pred_rsp_valid, e_vld);
            chk("taken", pred_taken, e_taken);
            chk("idx", pred_idx, e_idx);
            chk("ghr_o", pred_ghr, e_ghr);
        end
        if (rst) begin
            m_known = 1;
            m_init_left = 1024;
            foreach (m_pht[k]) m_pht[k] = 1;
            m_ghr = 0;
            e_vld = 0; e_taken = 0; e_idx = 0; e_ghr = 0;
        end else if (m_known && m_init_left > 0) begin
            m_init_left--;
            e_vld = 0;
        end else if (m_known) begin
            acc = pred_valid && !(upd_valid && upd_mispredict);
            e_vld = acc;
            if (acc) begin
                i = int'((pred_pc >> 2) % 1024) ^ m_ghr;
                c = m_pht[i];
`ifdef BP_BYPASS_EN
                if (upd_valid && int'(upd_idx) == i) c = sat(c, upd_taken);
`endif
                e_taken = (c >= 2);
                e_idx   = i[9:0];
                e_ghr   = m_ghr[9:0];
                m_ghr   = ((m_ghr * 2) + int'(e_taken)) % 1024;
            end
            if (upd_valid) begin
                m_pht[upd_idx] = sat(m_pht[upd_idx], upd_taken);
                if (upd_mispredict) m_ghr = ((int'(upd_ghr) * 2) + int'(upd_taken)) % 1024;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pc_for(input int t);
        logic [63:0] hi;
        hi = {$urandom, $urandom};
        return {hi[63:12], 10'((t ^ m_ghr) % 1024), hi[1:0]};
    endfunction

    // One cycle of traffic; rdy is pred_ready sampled mid-cycle.
    task automatic cyc(input logic pv, input logic [63:0] pc, input logic uv, input logic [9:0] ui,
                       input logic ut, input logic mp, input logic [9:0] ug, output logic rdy);
        pred_valid = pv; pred_pc = pc;
        upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_mispredict = mp; upd_ghr = ug;
        #1 rdy = pred_ready;
        step();
        pred_valid = 0; upd_valid = 0; upd_mispredict = 0;
    endtask

    task automatic count_init(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (pred_ready === 1'b1 || n >= 3000) break;
            n++;
        end
        step();
    endtask

    initial begin
        logic r;
        int n;
        rst = 1; step(); step();
        chk("rst_rsp_valid", pred_rsp_valid, 0);
        chk("rst_ghr_o", pred_ghr, 0);
        rst = 0;
        count_init(n);
        chk("init_cycles", n, 1024);

        cyc(1, 64'h1000, 0, 0, 0, 0, 0, r);
        chk("first_taken", pred_taken, 0);
        chk("first_idx", pred_idx, 10'h000);

        repeat (2) cyc(0, 0, 1, 10'h005, 1, 0, 0, r);
        cyc(1, pc_for(5), 0, 0, 0, 0, 0, r);
        chk("ctr11_taken", pred_taken, 1);
        chk("ghr_a", pred_ghr, 10'h000);
        repeat (3) cyc(0, 0, 1, 10'h005, 1, 0, 0, r);
        cyc(1, pc_for(5), 0, 0, 0, 0, 0, r);
        chk("sat_hi_taken", pred_taken, 1);
        chk("ghr_b", pred_ghr, 10'h001);
        repeat (4) cyc(0, 0, 1, 10'h005, 0, 0, 0, r);
        cyc(1, pc_for(5), 0, 0, 0, 0, 0, r);
        chk("ctr00_taken", pred_taken, 0);
        chk("ghr_c", pred_ghr, 10'h003);

        cyc(0, 0, 1, 10'h040, 1, 1, 10'h1FF, r);
        cyc(1, 64'h2000, 1, 10'h041, 0, 1, 10'h002, r);
        chk("mp_ready", r, 0);
        chk("mp_no_rsp", pred_rsp_valid, 0);
        cyc(1, pc_for(10'h042), 0, 0, 0, 0, 0, r);
        chk("mp_ghr", pred_ghr, 10'h004);

        cyc(1, pc_for(10'h010), 1, 10'h010, 1, 0, 0, r);
`ifdef BP_BYPASS_EN
        chk("same_idx_taken", pred_taken, 1);
`else
        chk("same_idx_taken", pred_taken, 0);
`endif
        cyc(1, pc_for(10'h010), 0, 0, 0, 0, 0, r);
        chk("after_upd_taken", pred_taken, 1);

        for (int k = 0; k < 2000; k++) begin
            cyc($urandom_range(0, 3) != 0, pc_for($urandom_range(0, 31)),
                $urandom_range(0, 1) == 1, 10'($urandom_range(0, 31)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, 10'($urandom), r);
        end

        pred_valid = 1; pred_pc = pc_for(3); upd_valid = 1; upd_idx = 3; upd_taken = 1;
        rst = 1; step();
        rst = 0; pred_valid = 0; upd_valid = 0;
        chk("midrst_rsp_valid", pred_rsp_valid, 0);
        chk("midrst_taken", pred_taken, 0);
        chk("midrst_idx", pred_idx, 0);
        count_init(n);
        chk("init_cycles_2", n, 1024);

        rst = 1; step(); rst = 0;
        repeat (500) step();
        rst = 1; step(); rst = 0;
        count_init(n);
        chk("init_cycles_3", n, 1024);

        for (int k = 0; k < 16; k++) begin
            int t;
            t = $urandom_range(0, 1023);
            cyc(1, pc_for(t), 0, 0, 0, 0, 0, r);
            chk("swept_lo", pred_taken, 0);
            cyc(0, 0, 1, 10'(t), 1, 0, 0, r);
            cyc(1, pc_for(t), 0, 0, 0, 0, 0, r);
            chk("swept_01", pred_taken, 1);
            cyc(0, 0, 1, 10'(t), 0, 0, 0, r);
        end
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
